// File: rtl/tj_trig_seq.sv
// tj_trig_seq: four-block plaintext sequence detector that arms a trigger.
// The FSM walks IDLE -> M1 -> M2 -> M3 -> ARMED as the plaintexts
// SEQ0..SEQ3 appear on successive valid strobes (idle gaps allowed).
// A wrong block mid-sequence restarts at M1 if it is SEQ0, else at IDLE.
// Optional macro TJ_TRIG_TIMEOUT_EN: ARMED lasts HOLD_CYCLES clocks and
// then falls back to IDLE; without it ARMED is sticky until reset.
module tj_trig_seq #(
  parameter logic [127:0] SEQ0        = 128'h00112233445566778899AABBCCDDEEFF,
  parameter logic [127:0] SEQ1        = 128'h0123456789ABCDEF0123456789ABCDEF,
  parameter logic [127:0] SEQ2        = 128'hFEDCBA9876543210FEDCBA9876543210,
  parameter logic [127:0] SEQ3        = 128'h3243F6A8885A308D313198A2E0370734,
  parameter logic [15:0]  HOLD_CYCLES = 16'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic         state_valid,
  output logic         Tj_Trig,
  output logic [2:0]   seq_stage
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] M1    = 3'd1;
  localparam logic [2:0] M2    = 3'd2;
  localparam logic [2:0] M3    = 3'd3;
  localparam logic [2:0] ARMED = 3'd4;

  logic [2:0] fsm_q, fsm_d;
  logic       trig_q, trig_d;
  logic       isSeq0, isSeq1, isSeq2, isSeq3;

  assign isSeq0 = (state == SEQ0);
  assign isSeq1 = (state == SEQ1);
  assign isSeq2 = (state == SEQ2);
  assign isSeq3 = (state == SEQ3);

`ifdef TJ_TRIG_TIMEOUT_EN
  logic [15:0] hold_q, hold_d;
  logic        holdDone;

  assign holdDone = (hold_q == 16'd0);
`endif

  // Next-state logic: forward advance beats restart, restart beats IDLE.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: begin
        if (state_valid && isSeq0) fsm_d = M1;
      end
      M1: begin
        if (state_valid) begin
          if (isSeq1)      fsm_d = M2;
          else if (isSeq0) fsm_d = M1;
          else             fsm_d = IDLE;
        end
      end
      M2: begin
        if (state_valid) begin
          if (isSeq2)      fsm_d = M3;
          else if (isSeq0) fsm_d = M1;
          else             fsm_d = IDLE;
        end
      end
      M3: begin
        if (state_valid) begin
          if (isSeq3)      fsm_d = ARMED;
          else if (isSeq0) fsm_d = M1;
          else             fsm_d = IDLE;
        end
      end
      ARMED: begin
`ifdef TJ_TRIG_TIMEOUT_EN
        if (holdDone) fsm_d = IDLE;
`else
        fsm_d = ARMED;
`endif
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Trigger tracks the registered FSM: high exactly while ARMED.
  always_comb begin
    trig_d = (fsm_d == ARMED);
  end

`ifdef TJ_TRIG_TIMEOUT_EN
  // Hold counter: load HOLD_CYCLES-1 on entry to ARMED, count down inside it.
  always_comb begin
    hold_d = hold_q;
    if (fsm_q != ARMED && fsm_d == ARMED) begin
      hold_d = HOLD_CYCLES - 16'd1;
    end else if (fsm_q == ARMED && !holdDone) begin
      hold_d = hold_q - 16'd1;
    end else if (fsm_d != ARMED) begin
      hold_d = 16'd0;
    end
  end

  // Hold counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) hold_q <= 16'd0;
    else      hold_q <= hold_d;
  end
`endif

  // FSM and trigger registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q  <= IDLE;
      trig_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      trig_q <= trig_d;
    end
  end

  assign Tj_Trig   = trig_q;
  assign seq_stage = fsm_q;

endmodule
